clmul32_seq: RTL
================

CLMUL32_SEQ -- requirements
Module: clmul32_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; SHALL be even and >= 8.
REQ-002 Port: clk  input  1  rising-edge clock; the block SHALL use only this clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operand pair presented.
REQ-005 Port: in_ready  output  1  block can accept an operand pair.
REQ-006 Port: x  input  WIDTH  first operand, sampled on accept.
REQ-007 Port: y  input  WIDTH  second operand, sampled on accept.
REQ-008 Port: out_valid  output  1  result valid.
REQ-009 Port: out_ready  input  1  consumer takes the result.
REQ-010 Port: z  output  2*WIDTH  carryless product x*y over GF(2).
REQ-011 Port: busy  output  1  high in every state other than IDLE.

Function
REQ-012 The block SHALL compute z with one shared H x H carryless multiplier (H = WIDTH/2), used over three sequenced Karatsuba passes.
REQ-013 FSM states SHALL be IDLE, MUL_LO, MUL_HI, MUL_MID and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 Accept SHALL occur on the cycle where in_valid & in_ready: x and y are latched and the FSM goes to MUL_LO.
REQ-016 MUL_LO SHALL register p_lo = xl*yl and go to MUL_HI.
REQ-017 MUL_HI SHALL register p_hi = xh*yh and go to MUL_MID.
REQ-018 MUL_MID SHALL register p_mid = (xl^xh)*(yl^yh) and go to DONE.
REQ-019 Each product SHALL be 2H bits wide; xl/yl are the low H bits of x/y and xh/yh the high H bits.
REQ-020 In DONE, z SHALL equal {p_hi, p_lo} XOR ((p_lo^p_hi^p_mid) zero-extended to 2*WIDTH and shifted left by H).
REQ-021 In DONE, out_valid SHALL be 1.
REQ-022 Latency: an accept in cycle N SHALL give out_valid=1 in cycle N+4.
REQ-023 DONE SHALL hold z and out_valid stable until out_ready=1, then go to IDLE on the next edge.
REQ-024 No new accept SHALL occur in the same cycle as result handoff; minimum issue interval is 5 cycles.
REQ-025 Outside DONE, z SHALL be 0 and out_valid SHALL be 0.
REQ-026 in_valid and input changes while not in IDLE SHALL be ignored and SHALL NOT affect the result in flight.
REQ-027 out_ready outside DONE SHALL have no effect.

Reset
REQ-028 While reset=1 at a rising edge, the FSM SHALL go to IDLE and operand/product registers SHALL clear to 0.
REQ-029 Output values during reset: in_ready=1, out_valid=0, busy=0, z=0.
REQ-030 Reset in any state, including mid-operation, SHALL discard the operation in flight; no out_valid SHALL follow for it.
REQ-031 Reset has priority over accept and over handoff in the same cycle.

Structure
REQ-032 Shared package clmul_pkg SHALL hold the FSM state enum typedef and the default width constant (32).
REQ-033 One sub-module, clmul_core, SHALL implement the combinational H x H shift-XOR carryless multiply (parameter N = H); clmul32_seq SHALL instantiate it exactly once.

Verification
REQ-034 Basic: x=1, y=1 accepted in cycle 0 -> out_valid=1 in cycle 4, z=0x0000000000000001.
REQ-035 Carry-free product: x=3, y=3 -> z=0x0000000000000005.
REQ-036 Full operands: x=y=0xFFFFFFFF -> z=0x5555555555555555. Top bits: x=y=0x80000000 -> z=0x4000000000000000.
REQ-037 Middle term: x=y=0x00010000 -> z=0x0000000100000000.
REQ-038 Backpressure: out_ready=0 for 5 cycles after out_valid rises -> z stable; in_ready=0 and busy=1 throughout; IDLE one cycle after out_ready=1.
REQ-039 Reset mid-operation: reset=1 for one cycle while in MUL_HI -> in_ready=1 next cycle, out_valid stays 0, and a following accept of x=3, y=3 gives z=5 four cycles later.

Source files
------------

// File: rtl/clmul_pkg.sv
// clmul_pkg
//   Shared definitions for the sequential carryless multiplier:
//   - CLMUL_WIDTH   : default operand width in bits
//   - clmul_state_e : FSM state encoding for clmul32_seq
package clmul_pkg;

    localparam int CLMUL_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        MUL_LO,
        MUL_HI,
        MUL_MID,
        DONE
    } clmul_state_e;

endpackage

// File: rtl/clmul_core.sv
// clmul_core
//   Combinational N x N carryless (GF(2)) multiplier built from shift-XOR
//   partial products.
//   Ports:
//     a_i [N-1:0]   first operand
//     b_i [N-1:0]   second operand
//     p_o [2N-1:0]  carryless product a_i * b_i
module clmul_core #(
    parameter int N = 16
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);

    logic [2*N-1:0] acc;

    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (b_i[i]) begin
                acc = acc ^ ({{N{1'b0}}, a_i} << i);
            end
        end
    end

    assign p_o = acc;

endmodule

// File: rtl/clmul32_seq.sv
// clmul32_seq
//   Sequential WIDTH x WIDTH carryless multiplier. One shared H x H core
//   (H = WIDTH/2) is time-multiplexed over three Karatsuba passes:
//     p_lo = xl*yl, p_hi = xh*yh, p_mid = (xl^xh)*(yl^yh)
//     z    = {p_hi, p_lo} ^ ((p_lo ^ p_hi ^ p_mid) << H)
//   Accept in cycle N gives out_valid in cycle N+4; the result is held
//   until out_ready, then the block returns to IDLE.
//   WIDTH must be even and >= 8.
//   Ports:
//     clk        rising-edge clock
//     reset      synchronous active-high reset
//     in_valid   operand pair presented
//     in_ready   high only in IDLE
//     x, y       operands, sampled on accept
//     out_valid  result valid (DONE state)
//     out_ready  consumer takes the result
//     z          carryless product, zero outside DONE
//     busy       high in every state other than IDLE
module clmul32_seq
    import clmul_pkg::*;
#(
    parameter int WIDTH = CLMUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   z,
    output logic                 busy
);

    localparam int H = WIDTH / 2;

    clmul_state_e       state_q;
    logic [WIDTH-1:0]   x_q, y_q;
    logic [WIDTH-1:0]   p_lo_q, p_hi_q, p_mid_q;
    logic               in_ready_q, out_valid_q, busy_q;

    logic [H-1:0]       core_a, core_b;
    logic [WIDTH-1:0]   core_p;
    logic [WIDTH-1:0]   mid_term;
    logic [2*WIDTH-1:0] z_comb;

    // Operand steering for the shared core, one Karatsuba pass per state.
    always_comb begin
        core_a = '0;
        core_b = '0;
        case (state_q)
            MUL_LO: begin
                core_a = x_q[H-1:0];
                core_b = y_q[H-1:0];
            end
            MUL_HI: begin
                core_a = x_q[WIDTH-1:H];
                core_b = y_q[WIDTH-1:H];
            end
            MUL_MID: begin
                core_a = x_q[H-1:0] ^ x_q[WIDTH-1:H];
                core_b = y_q[H-1:0] ^ y_q[WIDTH-1:H];
            end
            default: ;
        endcase
    end

    clmul_core #(
        .N (H)
    ) u_core (
        .a_i (core_a),
        .b_i (core_b),
        .p_o (core_p)
    );

    // Karatsuba recombination from the three registered products; forced
    // to zero outside DONE so z is only non-zero while out_valid is high.
    always_comb begin
        mid_term = p_lo_q ^ p_hi_q ^ p_mid_q;
        z_comb   = '0;
        if (state_q == DONE) begin
            z_comb = {p_hi_q, p_lo_q} ^ ({{WIDTH{1'b0}}, mid_term} << H);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            p_lo_q      <= '0;
            p_hi_q      <= '0;
            p_mid_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q        <= x;
                        y_q        <= y;
                        state_q    <= MUL_LO;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                MUL_LO: begin
                    p_lo_q  <= core_p;
                    state_q <= MUL_HI;
                end
                MUL_HI: begin
                    p_hi_q  <= core_p;
                    state_q <= MUL_MID;
                end
                MUL_MID: begin
                    p_mid_q     <= core_p;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign z         = z_comb;

endmodule
